axi_gran_burst_splitter_ax_chan: RTL and testbench
==================================================

Name: axi_gran_burst_splitter_ax_chan

Overview:
Upstream AX-channel stage of the granular burst splitter. It accepts one AXI AW or AR burst, registers the burst with the per-ID beat counters, and re-issues it as a sequence of sub-bursts. Each sub-burst has at most len_limit_i+1 beats. The block drives the counter allocation handshake directly (alloc_id/alloc_len/alloc_req/alloc_gnt) and feeds the downstream AX port toward the memory/interconnect.

Parameters:
AddrWidth, 64, AX address width in bits
IdWidth, 4, AX ID width
UserWidth, 1, AX user width
CutPath, 0, when 1 the sub-burst output passes through a spill register (one extra cycle of latency, full throughput)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
len_limit_i  in  8  maximum sub-burst length, AXI len encoding (beats-1); sampled when a burst is accepted
ax_id_i  in  IdWidth  incoming burst ID
ax_addr_i  in  AddrWidth  incoming start address
ax_len_i  in  8  incoming len (beats-1)
ax_size_i  in  3  incoming beat size
ax_burst_i  in  2  incoming burst type
ax_user_i  in  UserWidth  incoming user
ax_valid_i  in  1  incoming valid
ax_ready_o  out  1  incoming ready
alloc_id_o  out  IdWidth  ID to allocate in the counters
alloc_len_o  out  8  original ax_len to allocate
alloc_req_o  out  1  allocation request
alloc_gnt_i  in  1  allocation grant
sub_id_o / sub_addr_o / sub_len_o / sub_size_o / sub_burst_o / sub_user_o  out  as inputs  sub-burst fields
sub_valid_o  out  1  sub-burst valid
sub_ready_i  in  1  sub-burst ready

Behaviour:
- Reset (rst_i high, asynchronous):
  - FSM returns to IDLE.
  - All registers are cleared to '0.
  - ax_ready_o=0, alloc_req_o=0, sub_valid_o=0.
  - A burst that was in flight is dropped; counter-side cleanup is the counters' own reset.
- IDLE:
  - alloc_req_o = ax_valid_i; alloc_id_o and alloc_len_o mirror ax_id_i and ax_len_i combinationally.
  - ax_ready_o = alloc_gnt_i. The input and allocation handshakes complete in the same cycle; neither completes alone.
  - On the handshake, latch id, addr, size, burst, user and lim=len_limit_i.
  - Set rem = ax_len_i (beats-1 still to issue). Go to BUSY.
- BUSY:
  - ax_ready_o=0, alloc_req_o=0, sub_valid_o=1.
  - sub_len_o = min(rem, lim), except WRAP bursts, which are issued unsplit with sub_len_o=rem.
  - sub_addr_o = current address register.
  - Once sub_valid_o is high, all sub_* outputs stay stable until sub_ready_i.
  - On each sub handshake:
    - If sub_len_o == rem, the burst is finished: go to IDLE.
    - Otherwise rem <= rem - (sub_len_o+1).
    - INCR: addr <= addr + ((sub_len_o+1) << size), modulo 2^AddrWidth.
    - FIXED: addr is unchanged.
- Throughput: the next burst can be accepted in the cycle after the last sub handshake, so the minimum gap between bursts is one idle cycle.
- Latency: the first sub_valid_o rises one cycle after the accept (two cycles with CutPath=1).
- Arithmetic:
  - rem and lim are 8 bit; sub_len_o+1 is computed in 9 bits.
  - The address increment is computed as (9-bit beats) << size, zero-extended to AddrWidth.
- Boundary conditions:
  - lim=255 or ax_len=0: a single sub-burst equal to the original.
  - lim=0: every beat becomes its own sub-burst.
  - A burst type of 2'b11 (reserved) is forwarded unsplit, like WRAP.
  - len_limit_i changes during BUSY are ignored until the next accept.

Optional Feature:
Macro AXI_GRAN_SPLIT_STATS_EN.
- Defined:
  - Adds output stat_sub_cnt_o [31:0] counting sub-burst handshakes.
  - Adds output stat_burst_cnt_o [31:0] counting accepted bursts.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Shared package axi_gran_pkg holds:
  - typedef len_t (logic[7:0]);
  - enum split_state_e {IDLE, BUSY};
  - constant BurstFixed/Incr/Wrap encodings;
  - function next_addr(addr, len, size, burst).
- The sub-burst output register is the existing spill_register. No new sub-module is needed.

Test Plan:
- INCR addr 0x1000, len=15, size=3, lim=3 → four sub-bursts: addr 0x1000/0x1020/0x1040/0x1060, len 3 each; alloc_len_o=15 on the accept cycle.
- INCR len=9, lim=3 → sub lens 3,3,1; addresses advance by 32,32 bytes (size=3); return to IDLE after the third handshake.
- FIXED addr 0x200, len=7, lim=1 → four sub-bursts, all addr 0x200, len 1.
- WRAP len=7, lim=1 → one sub-burst, len 7, unchanged address.
- ax_valid_i=1 held with alloc_gnt_i=0 for 5 cycles → ax_ready_o stays 0, no sub_valid_o; grant in cycle 6 → accept that cycle.
- sub_ready_i stalled 3 cycles mid-burst → sub_* outputs stable. Then assert rst_i mid-burst → sub_valid_o=0 immediately; the next burst is accepted normally after reset.

Source files
------------

// File: rtl/axi_gran_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_gran_pkg
// Purpose : Shared types, burst encodings and the sub-burst address helper
//           for the granular burst splitter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package axi_gran_pkg;

    typedef logic [7:0] len_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } split_state_e;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    // Start address of the sub-burst following one of (len+1) beats.
    // Works on a 64-bit zero-extended address; callers truncate.
    function automatic logic [63:0] next_addr(
        input logic [63:0] addr,
        input len_t        len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [8:0]  beats;
        logic [63:0] step;
        beats = {1'b0, len} + 9'd1;
        step  = {55'd0, beats} << size;
        if (burst == BurstIncr) begin
            return addr + step;
        end
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spill_register.sv
`default_nettype none
// ============================================================================
// Module  : spill_register
// Purpose : Two-entry valid/ready pipeline register. Breaks the combinational
//           path on both valid/data and ready while sustaining one transfer
//           per cycle.
// Ports   : clk_i, rst_i (async, active-high)
//           valid_i/ready_o/data_i  - upstream handshake
//           valid_o/ready_i/data_o  - downstream handshake
// Revision: 1.0 - initial release
// ============================================================================
module spill_register #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             out_full_q,  out_full_d;
    logic [Width-1:0] out_data_q,  out_data_d;
    logic             skid_full_q, skid_full_d;
    logic [Width-1:0] skid_data_q, skid_data_d;

    assign ready_o = ~skid_full_q;
    assign valid_o = out_full_q;
    assign data_o  = out_data_q;

    always_comb begin
        out_full_d  = out_full_q;
        out_data_d  = out_data_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (!out_full_q || ready_i) begin
            // Output slot frees up: refill from the skid entry first to keep order.
            if (skid_full_q) begin
                out_full_d  = 1'b1;
                out_data_d  = skid_data_q;
                skid_full_d = 1'b0;
            end else if (valid_i) begin
                out_full_d = 1'b1;
                out_data_d = data_i;
            end else begin
                out_full_d = 1'b0;
            end
        end else if (valid_i && !skid_full_q) begin
            skid_full_d = 1'b1;
            skid_data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_full_q  <= 1'b0;
            out_data_q  <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            out_full_q  <= out_full_d;
            out_data_q  <= out_data_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_gran_burst_splitter_ax_chan.sv
`default_nettype none
// ============================================================================
// Module  : axi_gran_burst_splitter_ax_chan
// Purpose : Accepts one AXI AW/AR burst, allocates it in the per-ID beat
//           counters and re-issues it as sub-bursts of at most lim+1 beats.
//           WRAP and reserved burst types are forwarded unsplit.
// Ports   : clk_i, rst_i (async, active-high), len_limit_i
//           ax_*      - incoming burst (valid/ready)
//           alloc_*   - counter allocation handshake (req/gnt)
//           sub_*     - outgoing sub-bursts (valid/ready)
//           stat_*    - handshake statistics (only with AXI_GRAN_SPLIT_STATS_EN)
// Options : define AXI_GRAN_SPLIT_STATS_EN to add the statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
module axi_gran_burst_splitter_ax_chan
    import axi_gran_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned CutPath   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           len_limit_i,
    input  logic [IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    input  logic [UserWidth-1:0] ax_user_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    output logic [IdWidth-1:0]   alloc_id_o,
    output logic [7:0]           alloc_len_o,
    output logic                 alloc_req_o,
    input  logic                 alloc_gnt_i,
    output logic [IdWidth-1:0]   sub_id_o,
    output logic [AddrWidth-1:0] sub_addr_o,
    output logic [7:0]           sub_len_o,
    output logic [2:0]           sub_size_o,
    output logic [1:0]           sub_burst_o,
    output logic [UserWidth-1:0] sub_user_o,
    output logic                 sub_valid_o,
`ifdef AXI_GRAN_SPLIT_STATS_EN
    output logic [31:0]          stat_sub_cnt_o,
    output logic [31:0]          stat_burst_cnt_o,
`endif
    input  logic                 sub_ready_i
);

    localparam int unsigned SubWidth = IdWidth + AddrWidth + 8 + 3 + 2 + UserWidth;

    split_state_e         state_q, state_d;
    logic [IdWidth-1:0]   id_q,    id_d;
    logic [AddrWidth-1:0] addr_q,  addr_d;
    logic [2:0]           size_q,  size_d;
    logic [1:0]           burst_q, burst_d;
    logic [UserWidth-1:0] user_q,  user_d;
    len_t                 lim_q,   lim_d;
    len_t                 rem_q,   rem_d;

    len_t                 sub_len;
    logic                 src_valid;
    logic                 src_ready;
    logic [SubWidth-1:0]  src_data;
    logic [SubWidth-1:0]  dst_data;
    logic [63:0]          addr_ext;
    logic [63:0]          addr_nxt;

    assign alloc_id_o  = ax_id_i;
    assign alloc_len_o = ax_len_i;

    // WRAP (2'b10) and reserved (2'b11) share burst[1]; both go out unsplit.
    always_comb begin
        if (burst_q[1] || (rem_q < lim_q)) begin
            sub_len = rem_q;
        end else begin
            sub_len = lim_q;
        end
    end

    always_comb begin
        addr_ext                = '0;
        addr_ext[AddrWidth-1:0] = addr_q;
        addr_nxt                = next_addr(addr_ext, sub_len, size_q, burst_q);
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        burst_d     = burst_q;
        user_d      = user_q;
        lim_d       = lim_q;
        rem_d       = rem_q;
        ax_ready_o  = 1'b0;
        alloc_req_o = 1'b0;
        src_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Input and allocation complete together: ready follows grant,
                // request follows valid. Both are held low while in reset.
                ax_ready_o  = alloc_gnt_i & ~rst_i;
                alloc_req_o = ax_valid_i  & ~rst_i;
                if (ax_valid_i && alloc_gnt_i) begin
                    id_d    = ax_id_i;
                    addr_d  = ax_addr_i;
                    size_d  = ax_size_i;
                    burst_d = ax_burst_i;
                    user_d  = ax_user_i;
                    lim_d   = len_limit_i;
                    rem_d   = ax_len_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                src_valid = 1'b1;
                if (src_ready) begin
                    if (sub_len == rem_q) begin
                        state_d = IDLE;
                    end else begin
                        rem_d  = rem_q - sub_len - 8'd1;
                        addr_d = addr_nxt[AddrWidth-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            user_q  <= '0;
            lim_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            user_q  <= user_d;
            lim_q   <= lim_d;
            rem_q   <= rem_d;
        end
    end

    assign src_data = {id_q, addr_q, sub_len, size_q, burst_q, user_q};

    generate
        if (CutPath != 0) begin : g_cut
            spill_register #(
                .Width (SubWidth)
            ) i_spill (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .valid_i (src_valid),
                .ready_o (src_ready),
                .data_i  (src_data),
                .valid_o (sub_valid_o),
                .ready_i (sub_ready_i),
                .data_o  (dst_data)
            );
        end else begin : g_no_cut
            assign sub_valid_o = src_valid;
            assign src_ready   = sub_ready_i;
            assign dst_data    = src_data;
        end
    endgenerate

    assign {sub_id_o, sub_addr_o, sub_len_o, sub_size_o, sub_burst_o, sub_user_o} = dst_data;

`ifdef AXI_GRAN_SPLIT_STATS_EN
    logic [31:0] stat_sub_cnt_q,   stat_sub_cnt_d;
    logic [31:0] stat_burst_cnt_q, stat_burst_cnt_d;

    always_comb begin
        stat_sub_cnt_d   = stat_sub_cnt_q;
        stat_burst_cnt_d = stat_burst_cnt_q;
        if (sub_valid_o && sub_ready_i && (stat_sub_cnt_q != 32'hFFFF_FFFF)) begin
            stat_sub_cnt_d = stat_sub_cnt_q + 32'd1;
        end
        if (ax_valid_i && ax_ready_o && (stat_burst_cnt_q != 32'hFFFF_FFFF)) begin
            stat_burst_cnt_d = stat_burst_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_sub_cnt_q   <= '0;
            stat_burst_cnt_q <= '0;
        end else begin
            stat_sub_cnt_q   <= stat_sub_cnt_d;
            stat_burst_cnt_q <= stat_burst_cnt_d;
        end
    end

    assign stat_sub_cnt_o   = stat_sub_cnt_q;
    assign stat_burst_cnt_o = stat_burst_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_gran_burst_splitter_ax_chan.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_gran_burst_splitter_ax_chan
// Purpose : Directed bench for the AX-channel burst splitter: reset state,
//           grant stall, output stall with async reset, then a table of
//           bursts with hand-computed sub-burst addresses and lengths.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_gran_burst_splitter_ax_chan;

    logic        clk;
    logic        rst;
    logic [7:0]  len_limit;
    logic [3:0]  ax_id;
    logic [63:0] ax_addr;
    logic [7:0]  ax_len;
    logic [2:0]  ax_size;
    logic [1:0]  ax_burst;
    logic [0:0]  ax_user;
    logic        ax_valid;
    logic        ax_ready;
    logic [3:0]  alloc_id;
    logic [7:0]  alloc_len;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  sub_id;
    logic [63:0] sub_addr;
    logic [7:0]  sub_len;
    logic [2:0]  sub_size;
    logic [1:0]  sub_burst;
    logic [0:0]  sub_user;
    logic        sub_valid;
    logic        sub_ready;
`ifdef AXI_GRAN_SPLIT_STATS_EN
    logic [31:0] stat_sub_cnt;
    logic [31:0] stat_burst_cnt;
`endif

    axi_gran_burst_splitter_ax_chan #(
        .AddrWidth (64),
        .IdWidth   (4),
        .UserWidth (1),
        .CutPath   (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .len_limit_i (len_limit),
        .ax_id_i     (ax_id),
        .ax_addr_i   (ax_addr),
        .ax_len_i    (ax_len),
        .ax_size_i   (ax_size),
        .ax_burst_i  (ax_burst),
        .ax_user_i   (ax_user),
        .ax_valid_i  (ax_valid),
        .ax_ready_o  (ax_ready),
        .alloc_id_o  (alloc_id),
        .alloc_len_o (alloc_len),
        .alloc_req_o (alloc_req),
        .alloc_gnt_i (alloc_gnt),
        .sub_id_o    (sub_id),
        .sub_addr_o  (sub_addr),
        .sub_len_o   (sub_len),
        .sub_size_o  (sub_size),
        .sub_burst_o (sub_burst),
        .sub_user_o  (sub_user),
        .sub_valid_o (sub_valid),
`ifdef AXI_GRAN_SPLIT_STATS_EN
        .stat_sub_cnt_o   (stat_sub_cnt),
        .stat_burst_cnt_o (stat_burst_cnt),
`endif
        .sub_ready_i (sub_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [7:0]       lim;
        int               nsub;
        logic [3:0][63:0] exp_addr;
        logic [3:0][7:0]  exp_len;
    } vec_t;

    localparam int NumVec = 10;
    vec_t vecs [NumVec];

    int n_checks;
    int n_pass;
    int total_subs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(
        input int i, input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
        input logic [1:0] burst, input logic [7:0] lim, input int nsub,
        input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
        input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3
    );
        vecs[i].addr  = addr;
        vecs[i].len   = len;
        vecs[i].size  = size;
        vecs[i].burst = burst;
        vecs[i].lim   = lim;
        vecs[i].nsub  = nsub;
        vecs[i].exp_addr[0] = a0; vecs[i].exp_addr[1] = a1;
        vecs[i].exp_addr[2] = a2; vecs[i].exp_addr[3] = a3;
        vecs[i].exp_len[0]  = l0; vecs[i].exp_len[1]  = l1;
        vecs[i].exp_len[2]  = l2; vecs[i].exp_len[3]  = l3;
    endtask

    // Drive one burst with immediate grant, then drain every sub-burst with
    // sub_ready held high. Called right after a negative edge.
    task automatic run_burst(input int i);
        logic [3:0] id;
        bit         seen;
        id = 4'(i);
        ax_id     = id;
        ax_addr   = vecs[i].addr;
        ax_len    = vecs[i].len;
        ax_size   = vecs[i].size;
        ax_burst  = vecs[i].burst;
        ax_user   = 1'(i);
        len_limit = vecs[i].lim;
        ax_valid  = 1'b1;
        alloc_gnt = 1'b1;
        sub_ready = 1'b1;
        #1;
        check($sformatf("v%0d ax_ready", i), 64'(ax_ready), 64'd1);
        check($sformatf("v%0d alloc_req", i), 64'(alloc_req), 64'd1);
        check($sformatf("v%0d alloc_len", i), 64'(alloc_len), 64'(vecs[i].len));
        check($sformatf("v%0d alloc_id", i), 64'(alloc_id), 64'(id));
        @(posedge clk);
        @(negedge clk);
        ax_valid  = 1'b0;
        alloc_gnt = 1'b0;
        len_limit = ~vecs[i].lim;  // must be ignored until the next accept
        for (int k = 0; k < vecs[i].nsub; k++) begin
            seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                #1;
                if (sub_valid) seen = 1'b1;
                else @(negedge clk);
            end
            check($sformatf("v%0d s%0d valid", i, k), 64'(seen), 64'd1);
            check($sformatf("v%0d s%0d addr", i, k), sub_addr, vecs[i].exp_addr[k]);
            check($sformatf("v%0d s%0d len", i, k), 64'(sub_len), 64'(vecs[i].exp_len[k]));
            check($sformatf("v%0d s%0d id", i, k), 64'(sub_id), 64'(id));
            check($sformatf("v%0d s%0d size/burst/user", i, k),
                  64'({sub_size, sub_burst, sub_user}),
                  64'({vecs[i].size, vecs[i].burst, 1'(i)}));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check($sformatf("v%0d idle after last", i), 64'(sub_valid), 64'd0);
        total_subs += vecs[i].nsub;
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        total_subs = 0;

        //       i  addr                    len   sz    burst  lim    n  addr0..3                                                     len0..3
        set_vec(0, 64'h1000,               8'd15, 3'd3, 2'b01, 8'd3,   4, 64'h1000, 64'h1020, 64'h1040, 64'h1060,                   8'd3, 8'd3, 8'd3, 8'd3);
        set_vec(1, 64'h2000,               8'd9,  3'd3, 2'b01, 8'd3,   3, 64'h2000, 64'h2020, 64'h2040, 64'h0,                      8'd3, 8'd3, 8'd1, 8'd0);
        set_vec(2, 64'h200,                8'd7,  3'd2, 2'b00, 8'd1,   4, 64'h200,  64'h200,  64'h200,  64'h200,                    8'd1, 8'd1, 8'd1, 8'd1);
        set_vec(3, 64'h300,                8'd7,  3'd2, 2'b10, 8'd1,   1, 64'h300,  64'h0,    64'h0,    64'h0,                      8'd7, 8'd0, 8'd0, 8'd0);
        set_vec(4, 64'h4000,               8'd0,  3'd0, 2'b01, 8'd0,   1, 64'h4000, 64'h0,    64'h0,    64'h0,                      8'd0, 8'd0, 8'd0, 8'd0);
        set_vec(5, 64'h10,                 8'd2,  3'd1, 2'b01, 8'd0,   3, 64'h10,   64'h12,   64'h14,   64'h0,                      8'd0, 8'd0, 8'd0, 8'd0);
        set_vec(6, 64'h500,                8'd5,  3'd2, 2'b11, 8'd0,   1, 64'h500,  64'h0,    64'h0,    64'h0,                      8'd5, 8'd0, 8'd0, 8'd0);
        set_vec(7, 64'h800,                8'd200,3'd0, 2'b01, 8'd255, 1, 64'h800,  64'h0,    64'h0,    64'h0,                      8'd200, 8'd0, 8'd0, 8'd0);
        set_vec(8, 64'hFFFF_FFFF_FFFF_FFF8, 8'd3, 3'd2, 2'b01, 8'd1,   2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 64'h0,             8'd1, 8'd1, 8'd0, 8'd0);
        set_vec(9, 64'h40,                 8'd4,  3'd0, 2'b01, 8'd2,   2, 64'h40,   64'h43,   64'h0,    64'h0,                      8'd2, 8'd1, 8'd0, 8'd0);

        rst       = 1'b1;
        len_limit = 8'd0;
        ax_id     = '0;
        ax_addr   = '0;
        ax_len    = '0;
        ax_size   = '0;
        ax_burst  = '0;
        ax_user   = '0;
        ax_valid  = 1'b1;
        alloc_gnt = 1'b1;
        sub_ready = 1'b0;

        // Reset state: handshakes held off even with valid and grant high.
        @(negedge clk);
        @(negedge clk);
        check("reset ax_ready", 64'(ax_ready), 64'd0);
        check("reset alloc_req", 64'(alloc_req), 64'd0);
        check("reset sub_valid", 64'(sub_valid), 64'd0);
        rst       = 1'b0;
        ax_valid  = 1'b0;
        alloc_gnt = 1'b0;
        @(negedge clk);

        // Grant withheld for five cycles, granted on the sixth.
        ax_id    = 4'd5;
        ax_addr  = 64'h100;
        ax_len   = 8'd7;
        ax_size  = 3'd0;
        ax_burst = 2'b01;
        ax_user  = 1'b1;
        len_limit = 8'd1;
        ax_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("nogrant c%0d ax_ready", c), 64'(ax_ready), 64'd0);
            check($sformatf("nogrant c%0d alloc_req", c), 64'(alloc_req), 64'd1);
            check($sformatf("nogrant c%0d sub_valid", c), 64'(sub_valid), 64'd0);
            @(negedge clk);
        end
        alloc_gnt = 1'b1;
        #1;
        check("grant ax_ready", 64'(ax_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ax_valid  = 1'b0;
        alloc_gnt = 1'b0;
        #1;
        check("stall s0 valid", 64'(sub_valid), 64'd1);
        check("stall s0 addr", sub_addr, 64'h100);
        check("stall s0 len", 64'(sub_len), 64'd1);
        sub_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sub_ready = 1'b0;
        // Second sub-burst held for three cycles: outputs must not move.
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall c%0d valid", c), 64'(sub_valid), 64'd1);
            check($sformatf("stall c%0d addr", c), sub_addr, 64'h102);
            check($sformatf("stall c%0d len", c), 64'(sub_len), 64'd1);
            check($sformatf("stall c%0d id", c), 64'(sub_id), 64'd5);
            @(negedge clk);
        end
        // Asynchronous reset mid-burst drops it immediately.
        #2;
        rst = 1'b1;
        #1;
        check("async rst sub_valid", 64'(sub_valid), 64'd0);
        check("async rst ax_ready", 64'(ax_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NumVec; i++) begin
            run_burst(i);
        end

`ifdef AXI_GRAN_SPLIT_STATS_EN
        check("stat bursts", 64'(stat_burst_cnt), 64'(NumVec));
        check("stat subs", 64'(stat_sub_cnt), 64'(total_subs));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
